jedro_1_alu_md: RTL and testbench
=================================

JEDRO_1_ALU_MD -- requirements
Module: jedro_1_alu_md

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width (even, >=8) SHALL be honoured everywhere.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, destination-address width SHALL be honoured.
REQ-003 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rstn_i  in  1  asynchronous, active-low reset; SHALL act immediately on assertion, independent of clk_i.
REQ-005 valid_i  in  1  request valid.
REQ-006 ready_o  out  1  unit can accept a request this cycle.
REQ-007 sel_i  in  5  operation select.
REQ-008 op_a_i, op_b_i  in  DATA_WIDTH  operands.
REQ-009 dest_addr_i  in  REG_ADDR_WIDTH; wb_i  in  1  sideband, carried with request.
REQ-010 valid_o  out  1  result valid; out_ready_i  in  1  consumer accepts result.
REQ-011 res_o  out  DATA_WIDTH; ops_eq_o  out  1; overflow_o  out  1; dest_addr_o  out  REG_ADDR_WIDTH; wb_o  out  1; all registered.

Function
REQ-012 Encodings SHALL be: ADD 00h, SUB 08h, SLL 01h, SLT 02h, SLTU 03h, XOR 04h, SRL 05h, SRA 0Dh, OR 06h, AND 07h, DIV 10h, DIVU 11h, REM 12h, REMU 13h; any other code SHALL give res_o=0.
REQ-013 Accept = valid_i && ready_o at a rising edge; operands, sel_i, dest_addr_i, wb_i SHALL be captured at accept and never re-sampled.
REQ-014 FSM states IDLE, DIV, HOLD; IDLE->HOLD on accept of non-divide or fast-path divide; IDLE->DIV on accept of other divide; DIV->HOLD after iteration DATA_WIDTH; HOLD->IDLE on out_ready_i without new accept; HOLD->HOLD/DIV on simultaneous out_ready_i and accept.
REQ-015 ready_o SHALL be 1 in IDLE, 1 in HOLD only when out_ready_i=1, 0 in DIV (combinational on out_ready_i only).
REQ-016 valid_o SHALL be 1 exactly in HOLD; outputs SHALL stay stable while valid_o=1 and out_ready_i=0.
REQ-017 Non-divide ops SHALL present valid_o on the cycle after accept (latency 1).
REQ-018 Shift amount SHALL be op_b[log2(DATA_WIDTH)-1:0]; SRA SHALL sign-extend.
REQ-019 SLT/SLTU SHALL return 1 or 0 zero-extended to DATA_WIDTH.
REQ-020 overflow_o SHALL be two's-complement signed overflow of ADD/SUB, 0 for all other ops.
REQ-021 ops_eq_o SHALL be (op_a==op_b) for every op.
REQ-022 Divide SHALL use restoring iteration, one quotient bit per cycle, on magnitudes; valid_o SHALL rise DATA_WIDTH+1 cycles after accept.
REQ-023 Signed divide: quotient negative iff operand signs differ; remainder SHALL take dividend sign; truncation toward zero.
REQ-024 Fast path (latency 1): divisor 0 -> DIV/DIVU all-ones, REM/REMU = op_a; signed MIN / -1 -> DIV = MIN, REM = 0.
REQ-025 Back-to-back single-cycle ops with out_ready_i=1 SHALL sustain one result per cycle.

Reset
REQ-026 On rstn_i=0: state IDLE, valid_o=0, res_o=0, ops_eq_o=0, overflow_o=0, dest_addr_o=0, wb_o=0, divider registers 0.
REQ-027 Reset during DIV or HOLD SHALL discard the operation; no valid_o after release until a new accept.
REQ-028 ready_o SHALL be 1 on the first edge after reset release.

Verification
REQ-029 ADD 7FFFFFFFh+1, out_ready_i=1 -> next cycle valid_o=1, res_o=80000000h, overflow_o=1; SUB 5-5 -> res_o=0, ops_eq_o=1.
REQ-030 SRA F0000000h by 4 -> FF000000h; SRL same -> 0F000000h; SLT FFFFFFFFh,1 -> 1; SLTU same -> 0.
REQ-031 DIV -7/2 -> valid_o at accept+33, res_o=FFFFFFFDh; REM -7/2 -> FFFFFFFFh; ready_o=0 during those 32 cycles.
REQ-032 DIVU 5/0 -> latency 1, res_o=FFFFFFFFh; REM 80000000h/FFFFFFFFh -> latency 1, res_o=0.
REQ-033 Hold result with out_ready_i=0 for 5 cycles -> res_o, dest_addr_o, wb_o stable, ready_o=0; raise out_ready_i with valid_i=1 -> new request accepted same edge.
REQ-034 Assert rstn_i mid-divide (cycle 10) -> all outputs 0 asynchronously; after release no valid_o; new ADD completes with latency 1.

Source files
------------

// File: rtl/jedro_1_alu_md.sv
// jedro_1_alu_md: single-cycle integer ALU with a multi-cycle restoring divider.
// Requests use a valid/ready handshake. Results are held in output registers
// until the consumer accepts them. Divide by zero and signed MIN / -1 finish
// in one cycle; every other divide steps one quotient bit per cycle.
module jedro_1_alu_md #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [4:0]                sel_i,
    input  logic [DATA_WIDTH-1:0]     op_a_i,
    input  logic [DATA_WIDTH-1:0]     op_b_i,
    input  logic [REG_ADDR_WIDTH-1:0] dest_addr_i,
    input  logic                      wb_i,
    output logic                      valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     res_o,
    output logic                      ops_eq_o,
    output logic                      overflow_o,
    output logic [REG_ADDR_WIDTH-1:0] dest_addr_o,
    output logic                      wb_o
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [SHW-1:0]        CNT_LAST = SHW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONES_W   = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_W    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SLL  = 5'h01;
    localparam logic [4:0] OP_SLT  = 5'h02;
    localparam logic [4:0] OP_SLTU = 5'h03;
    localparam logic [4:0] OP_XOR  = 5'h04;
    localparam logic [4:0] OP_SRL  = 5'h05;
    localparam logic [4:0] OP_OR   = 5'h06;
    localparam logic [4:0] OP_AND  = 5'h07;
    localparam logic [4:0] OP_SUB  = 5'h08;
    localparam logic [4:0] OP_SRA  = 5'h0D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DIV  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    state_e state_r, state_nxt_s;

    logic                      ready_s, accept_s;
    logic                      is_div_s, div_signed_s, div_rem_s;
    logic                      b_zero_s, fast_div_s;
    logic [SHW-1:0]            shamt_s;
    logic [DATA_WIDTH-1:0]     sum_s, diff_s;
    logic [DATA_WIDTH-1:0]     alu_res_s, fast_res_s, accept_res_s;
    logic                      alu_ovf_s;
    logic [DATA_WIDTH-1:0]     a_mag_s, b_mag_s;

    // Divider state: dividend/quotient shifter, partial remainder, divisor, step count.
    logic [DATA_WIDTH-1:0]     dvd_r, rem_r, dvs_r;
    logic [SHW-1:0]            cnt_r;
    logic                      neg_q_r, neg_rem_r, rem_sel_r;
    logic [DATA_WIDTH:0]       shift_s, trial_s;
    logic                      take_s;
    logic [DATA_WIDTH-1:0]     rem_nxt_s, q_nxt_s, div_res_s;

    // Output registers.
    logic [DATA_WIDTH-1:0]     res_r;
    logic                      ops_eq_r, ovf_r, wb_r;
    logic [REG_ADDR_WIDTH-1:0] dest_r;

    // Ready depends on state and out_ready_i only, never on valid_i.
    assign ready_s  = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && out_ready_i);
    assign accept_s = valid_i && ready_s;

    // Divide codes are 10h..13h: bit0 selects unsigned, bit1 selects remainder.
    assign is_div_s     = sel_i[4] && (sel_i[3:2] == 2'b00);
    assign div_signed_s = ~sel_i[0];
    assign div_rem_s    = sel_i[1];
    assign b_zero_s     = (op_b_i == ZERO_W);
    assign fast_div_s   = b_zero_s || (div_signed_s && (op_a_i == MIN_W) && (op_b_i == ONES_W));

    assign shamt_s = op_b_i[SHW-1:0];
    assign sum_s   = op_a_i + op_b_i;
    assign diff_s  = op_a_i - op_b_i;

    // Single-cycle ALU result and signed overflow for ADD/SUB.
    always_comb begin
        alu_res_s = ZERO_W;
        alu_ovf_s = 1'b0;
        case (sel_i)
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = (op_a_i[MSB] == op_b_i[MSB]) && (sum_s[MSB] != op_a_i[MSB]);
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = (op_a_i[MSB] != op_b_i[MSB]) && (diff_s[MSB] != op_a_i[MSB]);
            end
            OP_SLL:  alu_res_s = op_a_i << shamt_s;
            OP_SLT:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            OP_SLTU: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (op_a_i < op_b_i)};
            OP_XOR:  alu_res_s = op_a_i ^ op_b_i;
            OP_SRL:  alu_res_s = op_a_i >> shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(op_a_i) >>> shamt_s);
            OP_OR:   alu_res_s = op_a_i | op_b_i;
            OP_AND:  alu_res_s = op_a_i & op_b_i;
            default: alu_res_s = ZERO_W;
        endcase
    end

    // Fast-path divide results and the value loaded into res_r on accept.
    always_comb begin
        fast_res_s = ZERO_W;
        if (b_zero_s) begin
            fast_res_s = div_rem_s ? op_a_i : ONES_W;
        end else begin
            fast_res_s = div_rem_s ? ZERO_W : MIN_W;
        end
        if (!is_div_s) begin
            accept_res_s = alu_res_s;
        end else if (fast_div_s) begin
            accept_res_s = fast_res_s;
        end else begin
            accept_res_s = ZERO_W;
        end
    end

    // Operand magnitudes; two's-complement negation of MIN yields MIN, the correct unsigned magnitude.
    assign a_mag_s = (div_signed_s && op_a_i[MSB]) ? (ZERO_W - op_a_i) : op_a_i;
    assign b_mag_s = (div_signed_s && op_b_i[MSB]) ? (ZERO_W - op_b_i) : op_b_i;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shift_s   = {rem_r, dvd_r[MSB]};
        trial_s   = shift_s - {1'b0, dvs_r};
        take_s    = ~trial_s[DATA_WIDTH];
        rem_nxt_s = take_s ? trial_s[DATA_WIDTH-1:0] : shift_s[DATA_WIDTH-1:0];
        q_nxt_s   = {dvd_r[DATA_WIDTH-2:0], take_s};
        if (rem_sel_r) begin
            div_res_s = neg_rem_r ? (ZERO_W - rem_nxt_s) : rem_nxt_s;
        end else begin
            div_res_s = neg_q_r ? (ZERO_W - q_nxt_s) : q_nxt_s;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_HOLD: begin
                if (accept_s) begin
                    state_nxt_s = (is_div_s && !fast_div_s) ? ST_DIV : ST_HOLD;
                end else if ((state_r == ST_HOLD) && !out_ready_i) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Divider datapath: load magnitudes and signs on accept, then iterate while in DIV.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dvd_r     <= ZERO_W;
            rem_r     <= ZERO_W;
            dvs_r     <= ZERO_W;
            cnt_r     <= {SHW{1'b0}};
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            rem_sel_r <= 1'b0;
        end else if (accept_s && is_div_s) begin
            dvd_r     <= a_mag_s;
            rem_r     <= ZERO_W;
            dvs_r     <= b_mag_s;
            cnt_r     <= {SHW{1'b0}};
            neg_q_r   <= div_signed_s && (op_a_i[MSB] != op_b_i[MSB]);
            neg_rem_r <= div_signed_s && op_a_i[MSB];
            rem_sel_r <= div_rem_s;
        end else if (state_r == ST_DIV) begin
            dvd_r     <= q_nxt_s;
            rem_r     <= rem_nxt_s;
            cnt_r     <= cnt_r + SHW'(1);
        end
    end

    // Output registers: captured on accept, result overwritten on the last divide step.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            res_r    <= ZERO_W;
            ops_eq_r <= 1'b0;
            ovf_r    <= 1'b0;
            dest_r   <= {REG_ADDR_WIDTH{1'b0}};
            wb_r     <= 1'b0;
        end else if (accept_s) begin
            res_r    <= accept_res_s;
            ops_eq_r <= (op_a_i == op_b_i);
            ovf_r    <= alu_ovf_s;
            dest_r   <= dest_addr_i;
            wb_r     <= wb_i;
        end else if ((state_r == ST_DIV) && (cnt_r == CNT_LAST)) begin
            res_r    <= div_res_s;
        end
    end

    assign ready_o     = ready_s;
    assign valid_o     = (state_r == ST_HOLD);
    assign res_o       = res_r;
    assign ops_eq_o    = ops_eq_r;
    assign overflow_o  = ovf_r;
    assign dest_addr_o = dest_r;
    assign wb_o        = wb_r;

endmodule

// File: tb/tb_jedro_1_alu_md.sv
// Directed testbench for jedro_1_alu_md (DATA_WIDTH=32, REG_ADDR_WIDTH=5).
module tb_jedro_1_alu_md;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  sel_i;
    logic [31:0] op_a_i, op_b_i;
    logic [4:0]  dest_addr_i;
    logic        wb_i;
    logic        valid_o;
    logic        out_ready_i;
    logic [31:0] res_o;
    logic        ops_eq_o, overflow_o;
    logic [4:0]  dest_addr_o;
    logic        wb_o;

    int checks = 0;
    int errors = 0;
    int vec_n  = 0;

    always #5 clk_i = ~clk_i;

    jedro_1_alu_md #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
        .sel_i(sel_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .dest_addr_i(dest_addr_i),
        .wb_i(wb_i), .valid_o(valid_o), .out_ready_i(out_ready_i), .res_o(res_o),
        .ops_eq_o(ops_eq_o), .overflow_o(overflow_o), .dest_addr_o(dest_addr_o), .wb_o(wb_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Single-cycle request, issued back-to-back; result must be visible right after accept.
    task automatic fast(input string tag, input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic ovf, input logic eq);
        logic [4:0] d;
        vec_n++;
        d           = vec_n[4:0];
        valid_i     = 1'b1;
        sel_i       = sel;
        op_a_i      = a;
        op_b_i      = b;
        dest_addr_i = d;
        wb_i        = d[0];
        chk({tag, "_rdy"}, {31'd0, ready_o}, 32'd1);
        @(posedge clk_i); #1;
        chk({tag, "_vld"}, {31'd0, valid_o}, 32'd1);
        chk({tag, "_res"}, res_o, r);
        chk({tag, "_ovf"}, {31'd0, overflow_o}, {31'd0, ovf});
        chk({tag, "_eq"},  {31'd0, ops_eq_o}, {31'd0, eq});
        chk({tag, "_dst"}, {27'd0, dest_addr_o}, {27'd0, d});
        chk({tag, "_wb"},  {31'd0, wb_o}, {31'd0, d[0]});
    endtask

    // Iterative divide: result must appear 33 cycles after accept with ready low meanwhile.
    task automatic slow(input string tag, input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r);
        int   lat;
        logic rdy_seen;
        valid_i     = 1'b1;
        sel_i       = sel;
        op_a_i      = a;
        op_b_i      = b;
        dest_addr_i = 5'h0A;
        wb_i        = 1'b1;
        @(posedge clk_i); #1;
        valid_i  = 1'b0;
        lat      = 1;
        rdy_seen = (!valid_o && ready_o);
        while (!valid_o && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
            if (!valid_o && ready_o) rdy_seen = 1'b1;
        end
        chk({tag, "_lat"}, lat, 32'd33);
        chk({tag, "_rdy_low"}, {31'd0, rdy_seen}, 32'd0);
        chk({tag, "_res"}, res_o, r);
        chk({tag, "_ovf"}, {31'd0, overflow_o}, 32'd0);
        chk({tag, "_dst"}, {27'd0, dest_addr_o}, 32'h0000000A);
    endtask

    initial begin
        logic stable;
        logic seen;
        rstn_i      = 1'b0;
        valid_i     = 1'b0;
        out_ready_i = 1'b1;
        sel_i       = 5'h00;
        op_a_i      = 32'h0;
        op_b_i      = 32'h0;
        dest_addr_i = 5'h00;
        wb_i        = 1'b0;

        // Reset state
        #2;
        chk("rst_vld", {31'd0, valid_o}, 32'd0);
        chk("rst_res", res_o, 32'h0);
        chk("rst_dst", {27'd0, dest_addr_o}, 32'h0);
        chk("rst_flags", {29'd0, ops_eq_o, overflow_o, wb_o}, 32'h0);
        repeat (2) @(posedge clk_i);
        #3 rstn_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rel_rdy", {31'd0, ready_o}, 32'd1);
        chk("rel_vld", {31'd0, valid_o}, 32'd0);

        // Single-cycle ops and fast-path divides, back to back
        fast("add_ovf", 5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0);
        fast("sub_eq",  5'h08, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1);
        fast("sub_ovf", 5'h08, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0);
        fast("add",     5'h00, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b1);
        fast("sra",     5'h0D, 32'hF0000000, 32'h00000004, 32'hFF000000, 1'b0, 1'b0);
        fast("srl",     5'h05, 32'hF0000000, 32'h00000004, 32'h0F000000, 1'b0, 1'b0);
        fast("sll_msk", 5'h01, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b0);
        fast("slt",     5'h02, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
        fast("sltu",    5'h03, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0);
        fast("xor",     5'h04, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
        fast("or",      5'h06, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0, 1'b0);
        fast("and",     5'h07, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
        fast("bad_op",  5'h1F, 32'h00000003, 32'h00000003, 32'h00000000, 1'b0, 1'b1);
        fast("divu_z",  5'h11, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        fast("remu_z",  5'h13, 32'h00000009, 32'h00000000, 32'h00000009, 1'b0, 1'b0);
        fast("rem_min", 5'h12, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
        fast("div_min", 5'h10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0);
        valid_i = 1'b0;

        // Iterative divides
        slow("div_n7_2",  5'h10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        slow("rem_n7_2",  5'h12, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        slow("div_7_n2",  5'h10, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD);
        slow("rem_7_n2",  5'h12, 32'h00000007, 32'hFFFFFFFE, 32'h00000001);
        slow("divu_100",  5'h11, 32'h00000064, 32'h00000007, 32'h0000000E);
        slow("remu_100",  5'h13, 32'h00000064, 32'h00000007, 32'h00000002);
        slow("div_min_2", 5'h10, 32'h80000000, 32'h00000002, 32'hC0000000);

        // Output hold with back-pressure, then same-edge accept on release
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        valid_i     = 1'b1;
        sel_i       = 5'h00;
        op_a_i      = 32'd3;
        op_b_i      = 32'd4;
        dest_addr_i = 5'h15;
        wb_i        = 1'b1;
        @(posedge clk_i); #1;
        sel_i       = 5'h08;
        op_a_i      = 32'd10;
        op_b_i      = 32'd4;
        dest_addr_i = 5'h03;
        wb_i        = 1'b0;
        stable      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (res_o !== 32'd7 || dest_addr_o !== 5'h15 || wb_o !== 1'b1 || valid_o !== 1'b1 || ready_o !== 1'b0)
                stable = 1'b0;
            @(posedge clk_i); #1;
        end
        chk("hold_stable", {31'd0, stable}, 32'd1);
        chk("hold_res", res_o, 32'd7);
        out_ready_i = 1'b1;
        #1;
        chk("hold_rdy_up", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        chk("next_vld", {31'd0, valid_o}, 32'd1);
        chk("next_res", res_o, 32'd6);
        chk("next_dst", {27'd0, dest_addr_o}, 32'h00000003);
        chk("next_wb", {31'd0, wb_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("drain_vld", {31'd0, valid_o}, 32'd0);
        chk("drain_rdy", {31'd0, ready_o}, 32'd1);

        // Reset in the middle of a divide
        valid_i     = 1'b1;
        sel_i       = 5'h10;
        op_a_i      = 32'h64;
        op_b_i      = 32'h64;
        dest_addr_i = 5'h1F;
        wb_i        = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        chk("mid_dst", {27'd0, dest_addr_o}, 32'h0000001F);
        chk("mid_eq", {31'd0, ops_eq_o}, 32'd1);
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_vld", {31'd0, valid_o}, 32'd0);
        chk("arst_res", res_o, 32'h0);
        chk("arst_dst", {27'd0, dest_addr_o}, 32'h0);
        chk("arst_flags", {29'd0, ops_eq_o, overflow_o, wb_o}, 32'h0);
        #3 rstn_i = 1'b1;
        @(posedge clk_i); #1;
        chk("arel_rdy", {31'd0, ready_o}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) seen = 1'b1;
            @(posedge clk_i); #1;
        end
        chk("arel_no_vld", {31'd0, seen}, 32'd0);
        fast("arel_add", 5'h00, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
        valid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
